// File: rtl/riscv_pkg.sv
// Shared core constants: NOP encoding, fetch FSM
// state codes and the default boot address.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline holding register with enable,
// flush-to-NOP and asynchronous active-low reset.
module if_id_register
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] pc_d,
  input  logic [DATA_WIDTH-1:0] pc_plus4_d,
  input  logic [DATA_WIDTH-1:0] instr_d,
  output logic [DATA_WIDTH-1:0] pc_q,
  output logic [DATA_WIDTH-1:0] pc_plus4_q,
  output logic [DATA_WIDTH-1:0] instr_q,
  output logic                  valid_q
);

  localparam logic [DATA_WIDTH-1:0] NOP =
    DATA_WIDTH'(NOP_INSTR);

  // Flush wins over capture; PC fields are kept on
  // flush since only valid/instruction are meaningful.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= NOP;
      valid_q    <= 1'b0;
    end else if (flush) begin
      instr_q    <= NOP;
      valid_q    <= 1'b0;
    end else if (en) begin
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, BOOT/RUN/FAULT FSM,
// fetch counter and the IF/ID register.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC =
    DATA_WIDTH'(DEFAULT_RESET_PC),
  parameter int MEMORY_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall_i,
  input  logic                  Redirect_i,
  input  logic [DATA_WIDTH-1:0] Redirect_Target_i,
  output logic [DATA_WIDTH-1:0] Instr_Addr_o,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  output logic [DATA_WIDTH-1:0] IFID_PC_o,
  output logic [DATA_WIDTH-1:0] IFID_PC_Plus4_o,
  output logic [DATA_WIDTH-1:0] IFID_Instruction_o,
  output logic                  IFID_Valid_o,
  output logic                  Fault_o,
  output logic [DATA_WIDTH-1:0] Fetch_Count_o
);

  localparam int W2 = DATA_WIDTH + 2;
  localparam logic [W2-1:0] WIN_LO = {2'b00, RESET_PC};
  localparam logic [W2-1:0] WIN_HI =
    WIN_LO + W2'(4 * MEMORY_DEPTH);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_nxt;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0] count_nxt;
  logic                  pc_ok;
  logic                  cap;
  logic                  flush;

  assign pc_plus4 = pc + DATA_WIDTH'(4);

  // Window bounds widened so the upper limit never wraps.
  assign pc_ok = ({2'b00, pc} >= WIN_LO) &&
                 ({2'b00, pc} <  WIN_HI);

  // Next-state decode: fault > redirect > stall > step.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    count_nxt = count;
    cap       = 1'b0;
    flush     = 1'b0;
    unique case (state)
      ST_BOOT: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!pc_ok) begin
          state_nxt = ST_FAULT;
          flush     = 1'b1;
        end else if (Redirect_i) begin
          flush = 1'b1;
          if (Redirect_Target_i[1:0] != 2'b00)
            state_nxt = ST_FAULT;
          else
            pc_nxt = Redirect_Target_i;
        end else if (!Stall_i) begin
          cap       = 1'b1;
          pc_nxt    = pc_plus4;
          count_nxt = count + DATA_WIDTH'(1);
        end
      end
      ST_FAULT: begin
        flush = 1'b1;
      end
      default: begin
        state_nxt = ST_FAULT;
        flush     = 1'b1;
      end
    endcase
  end

  // State, PC and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
      count <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      count <= count_nxt;
    end
  end

  if_id_register #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .en         (cap),
    .flush      (flush),
    .pc_d       (pc),
    .pc_plus4_d (pc_plus4),
    .instr_d    (Instruction_i),
    .pc_q       (IFID_PC_o),
    .pc_plus4_q (IFID_PC_Plus4_o),
    .instr_q    (IFID_Instruction_o),
    .valid_q    (IFID_Valid_o)
  );

  assign Instr_Addr_o  = pc;
  assign Fault_o       = (state == ST_FAULT);
  assign Fetch_Count_o = count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: default build
// plus a MEMORY_DEPTH=4 build for window overrun.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        reset_a = 1'b1;
  logic        stall_a = 1'b0;
  logic        redir_a = 1'b0;
  logic [31:0] tgt_a   = '0;
  logic [31:0] addr_a;
  logic [31:0] instr_a;
  logic [31:0] pc_a;
  logic [31:0] pc4_a;
  logic [31:0] ins_a;
  logic        val_a;
  logic        flt_a;
  logic [31:0] cnt_a;

  logic        reset_b = 1'b1;
  logic [31:0] addr_b;
  logic [31:0] instr_b;
  logic [31:0] pc_b;
  logic [31:0] pc4_b;
  logic [31:0] ins_b;
  logic        val_b;
  logic        flt_b;
  logic [31:0] cnt_b;

  assign instr_a = addr_a;
  assign instr_b = addr_b;

  instruction_fetch u_dut_a (
    .clk                (clk),
    .reset              (reset_a),
    .Stall_i            (stall_a),
    .Redirect_i         (redir_a),
    .Redirect_Target_i  (tgt_a),
    .Instr_Addr_o       (addr_a),
    .Instruction_i      (instr_a),
    .IFID_PC_o          (pc_a),
    .IFID_PC_Plus4_o    (pc4_a),
    .IFID_Instruction_o (ins_a),
    .IFID_Valid_o       (val_a),
    .Fault_o            (flt_a),
    .Fetch_Count_o      (cnt_a)
  );

  instruction_fetch #(
    .MEMORY_DEPTH (4)
  ) u_dut_b (
    .clk                (clk),
    .reset              (reset_b),
    .Stall_i            (1'b0),
    .Redirect_i         (1'b0),
    .Redirect_Target_i  (32'h0),
    .Instr_Addr_o       (addr_b),
    .Instruction_i      (instr_b),
    .IFID_PC_o          (pc_b),
    .IFID_PC_Plus4_o    (pc4_b),
    .IFID_Instruction_o (ins_b),
    .IFID_Valid_o       (val_b),
    .Fault_o            (flt_b),
    .Fetch_Count_o      (cnt_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    reset_a = 1'b0;
    reset_b = 1'b0;
    #11;
    check("rst_addr",  addr_a, 32'h0040_0000);
    check("rst_pc",    pc_a,   32'h0);
    check("rst_pc4",   pc4_a,  32'h0);
    check("rst_instr", ins_a,  NOP);
    check("rst_valid", val_a,  1'b0);
    check("rst_fault", flt_a,  1'b0);
    check("rst_count", cnt_a,  32'h0);

    // small window: four fetches then overrun fault
    @(negedge clk) reset_b = 1'b1;
    tick();
    check("b_boot_valid", val_b, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b_pc",    pc_b,  32'h0040_0000 + 4 * i);
      check("b_pc4",   pc4_b, 32'h0040_0004 + 4 * i);
      check("b_count", cnt_b, i + 1);
      check("b_valid", val_b, 1'b1);
    end
    tick();
    check("b_fault",      flt_b,  1'b1);
    check("b_flt_valid",  val_b,  1'b0);
    check("b_flt_instr",  ins_b,  NOP);
    check("b_flt_count",  cnt_b,  32'd4);
    check("b_flt_addr",   addr_b, 32'h0040_0010);
    tick();
    check("b_flt_hold",   flt_b,  1'b1);
    check("b_flt_addr2",  addr_b, 32'h0040_0010);

    // default build: boot then sequential fetch
    @(negedge clk) reset_a = 1'b1;
    tick();
    check("boot_valid", val_a,  1'b0);
    check("boot_addr",  addr_a, 32'h0040_0000);
    check("boot_count", cnt_a,  32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seq_pc",    pc_a,  32'h0040_0000 + 4 * i);
      check("seq_pc4",   pc4_a, 32'h0040_0004 + 4 * i);
      check("seq_instr", ins_a, 32'h0040_0000 + 4 * i);
      check("seq_count", cnt_a, i + 1);
      check("seq_valid", val_a, 1'b1);
    end

    // stall three cycles
    @(negedge clk) stall_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stl_addr",  addr_a, 32'h0040_000C);
      check("stl_pc",    pc_a,   32'h0040_0008);
      check("stl_count", cnt_a,  32'd3);
      check("stl_valid", val_a,  1'b1);
    end
    @(negedge clk) stall_a = 1'b0;
    tick();
    check("res_pc",    pc_a,   32'h0040_000C);
    check("res_count", cnt_a,  32'd4);
    check("res_addr",  addr_a, 32'h0040_0010);

    // redirect beats stall
    @(negedge clk);
    redir_a = 1'b1;
    tgt_a   = 32'h0040_0040;
    stall_a = 1'b1;
    tick();
    check("rd_addr",  addr_a, 32'h0040_0040);
    check("rd_valid", val_a,  1'b0);
    check("rd_instr", ins_a,  NOP);
    check("rd_count", cnt_a,  32'd4);
    @(negedge clk);
    redir_a = 1'b0;
    stall_a = 1'b0;
    tick();
    check("rd2_pc",    pc_a,   32'h0040_0040);
    check("rd2_valid", val_a,  1'b1);
    check("rd2_count", cnt_a,  32'd5);
    check("rd2_addr",  addr_a, 32'h0040_0044);

    // misaligned redirect target faults
    @(negedge clk);
    redir_a = 1'b1;
    tgt_a   = 32'h0040_0042;
    tick();
    check("mis_fault", flt_a,  1'b1);
    check("mis_addr",  addr_a, 32'h0040_0044);
    check("mis_valid", val_a,  1'b0);
    check("mis_instr", ins_a,  NOP);
    check("mis_count", cnt_a,  32'd5);
    @(negedge clk) tgt_a = 32'h0040_0040;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("flt_fault", flt_a,  1'b1);
      check("flt_addr",  addr_a, 32'h0040_0044);
      check("flt_count", cnt_a,  32'd5);
    end
    @(negedge clk) redir_a = 1'b0;
    tick();
    check("flt_valid", val_a, 1'b0);
    check("flt_hold",  flt_a, 1'b1);

    // asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3;
    reset_a = 1'b0;
    #1;
    check("arst_fault", flt_a,  1'b0);
    check("arst_addr",  addr_a, 32'h0040_0000);
    check("arst_count", cnt_a,  32'h0);
    check("arst_valid", val_a,  1'b0);
    check("arst_pc",    pc_a,   32'h0);

    // redirect and stall are ignored during boot
    redir_a = 1'b1;
    tgt_a   = 32'h0040_0040;
    stall_a = 1'b1;
    @(negedge clk) reset_a = 1'b1;
    tick();
    check("bt_addr",  addr_a, 32'h0040_0000);
    check("bt_valid", val_a,  1'b0);
    check("bt_fault", flt_a,  1'b0);
    @(negedge clk);
    redir_a = 1'b0;
    stall_a = 1'b0;
    tick();
    check("bt_pc",    pc_a,  32'h0040_0000);
    check("bt_count", cnt_a, 32'd1);

    // aligned redirect above the window faults next edge
    @(negedge clk);
    redir_a = 1'b1;
    tgt_a   = 32'h0040_0080;
    tick();
    check("hi_addr",  addr_a, 32'h0040_0080);
    check("hi_fault", flt_a,  1'b0);
    @(negedge clk) redir_a = 1'b0;
    tick();
    check("hi_fault2", flt_a,  1'b1);
    check("hi_valid",  val_a,  1'b0);
    check("hi_count",  cnt_a,  32'd1);
    check("hi_addr2",  addr_a, 32'h0040_0080);

    // redirect below the window faults next edge
    @(negedge clk) reset_a = 1'b0;
    @(negedge clk) reset_a = 1'b1;
    tick();
    tick();
    check("lo_count", cnt_a, 32'd1);
    @(negedge clk);
    redir_a = 1'b1;
    tgt_a   = 32'h003F_FFFC;
    tick();
    check("lo_addr",  addr_a, 32'h003F_FFFC);
    check("lo_fault", flt_a,  1'b0);
    @(negedge clk) redir_a = 1'b0;
    tick();
    check("lo_fault2", flt_a, 1'b1);
    check("lo_count2", cnt_a, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of PC and instruction.
REQ-002 Parameter RESET_PC, default 32'h0040_0000, PC value loaded at reset.
REQ-003 Parameter MEMORY_DEPTH, default 32, program memory depth in words; fetch window is RESET_PC .. RESET_PC+4*MEMORY_DEPTH-4.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 Stall_i  input  1  hold PC and IF/ID register.
REQ-007 Redirect_i  input  1  branch/jump taken; load Redirect_Target_i.
REQ-008 Redirect_Target_i  input  DATA_WIDTH  redirect destination address.
REQ-009 Instr_Addr_o  output  DATA_WIDTH  current PC to program memory Address_i.
REQ-010 Instruction_i  input  DATA_WIDTH  combinational instruction from program memory.
REQ-011 IFID_PC_o  output  DATA_WIDTH  registered PC of fetched instruction.
REQ-012 IFID_PC_Plus4_o  output  DATA_WIDTH  registered PC+4.
REQ-013 IFID_Instruction_o  output  DATA_WIDTH  registered instruction, NOP when invalid.
REQ-014 IFID_Valid_o  output  1  IF/ID contents valid.
REQ-015 Fault_o  output  1  sticky fetch fault flag.
REQ-016 Fetch_Count_o  output  DATA_WIDTH  count of valid instructions delivered to IF/ID.

Function
REQ-017 The block SHALL implement states BOOT, RUN, FAULT.
REQ-018 BOOT SHALL last exactly one cycle after reset deassertion, SHALL load nothing into IF/ID, and SHALL transition to RUN.
REQ-019 In RUN with no stall/redirect, each edge SHALL capture {PC, PC+4, Instruction_i, valid=1} into IF/ID, set PC=PC+4 and increment Fetch_Count_o.
REQ-020 Per-edge priority SHALL be: fault detection > Redirect_i > Stall_i > sequential increment.
REQ-021 Redirect_i in RUN SHALL load PC=Redirect_Target_i, set IFID_Valid_o=0, set IFID_Instruction_o=32'h0000_0013, and leave Fetch_Count_o unchanged, regardless of Stall_i.
REQ-022 Stall_i without Redirect_i SHALL hold PC, all IF/ID outputs and Fetch_Count_o unchanged.
REQ-023 Redirect_i with Redirect_Target_i[1:0]!=0 SHALL transition to FAULT instead of redirecting.
REQ-024 A PC outside the fetch window in RUN SHALL transition to FAULT on the next edge without capturing the instruction.
REQ-025 In FAULT: PC frozen, IFID_Valid_o=0, IFID_Instruction_o=NOP, Fault_o=1, all inputs ignored, exit only by reset.
REQ-026 PC+4 SHALL wrap modulo 2^DATA_WIDTH; Fetch_Count_o SHALL wrap to 0 after all-ones.
REQ-027 Instr_Addr_o SHALL equal the PC register combinationally; zero-cycle fetch latency, one-cycle fetch-to-IF/ID latency.
REQ-028 Redirect_i and Stall_i in BOOT or FAULT SHALL have no effect.

Reset
REQ-029 reset low SHALL immediately force: state=BOOT, PC=RESET_PC, IFID_PC_o=0, IFID_PC_Plus4_o=0, IFID_Instruction_o=NOP, IFID_Valid_o=0, Fault_o=0, Fetch_Count_o=0.
REQ-030 reset asserted mid-operation, including in FAULT or during Stall_i, SHALL discard all state and behave identically to power-on reset.

Structure
REQ-031 NOP encoding 32'h0000_0013, state encoding and default RESET_PC SHALL live in the shared riscv_pkg package.
REQ-032 The IF/ID holding register (enable, flush, async reset) SHALL be a sub-module named if_id_register; PC, FSM and counter remain in instruction_fetch.

Verification
REQ-033 Reset release, no stall, Instruction_i=address echo -> cycle 1 Valid=0 (BOOT); then IFID_PC_o=0x00400000, 0x00400004, 0x00400008; Fetch_Count_o=1,2,3.
REQ-034 Stall_i high 3 cycles at PC=0x00400008 -> Instr_Addr_o, IF/ID, Fetch_Count_o unchanged 3 cycles; resume at 0x0040000C.
REQ-035 Redirect_i with target 0x00400040 while Stall_i=1 -> next Instr_Addr_o=0x00400040, Valid=0, instruction 0x00000013, count unchanged.
REQ-036 Redirect target 0x00400042 -> FAULT: Fault_o=1, PC frozen at pre-redirect value, Valid=0 until reset; reset low mid-cycle clears Fault_o asynchronously.
REQ-037 MEMORY_DEPTH=4, free run -> after four valid fetches (0x00400000..0x0040000C) PC=0x00400010 enters FAULT, Fetch_Count_o=4.
